// File: rtl/imm_gen_stage_pkg.sv
// imm_gen_stage_pkg: instruction formats, opcode constants and instruction views shared by the immediate stage.
package imm_gen_stage_pkg;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z, FMT_ILL} formats_t;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;
  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_type_t;
  typedef union packed {
    logic [31:0] raw;
    i_type_t     i;
  } instruction_t;
endpackage

// File: rtl/imm_gen_stage_extract.sv
// imm_extract: combinational immediate decode and malformed-format detection for one instruction word.
module imm_extract
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  formats_t        format_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);
  instruction_t w;
  logic shift;
  logic [XLEN-1:0] shamt;
  assign w = instr_i;
  assign shift = w.i.opcode == OP_IMM && (w.i.funct3 == F3_SLLI || w.i.funct3 == F3_SRLI_SRAI);
  assign shamt = XLEN == 64 ? XLEN'(w.raw[25:20]) : XLEN'(w.raw[24:20]);
  // RV32 shifts only have a 5-bit shamt, so bit 25 set is malformed
  assign illegal_o = format_i == FMT_ILL || (format_i == FMT_I && shift && XLEN == 32 && w.raw[25]);
  always_comb begin
    imm_o = '0;
    unique case (format_i)
      FMT_I:   imm_o = shift ? shamt : XLEN'($signed(w.raw[31:20]));
      FMT_S:   imm_o = XLEN'($signed({w.raw[31:25], w.raw[11:7]}));
      FMT_B:   imm_o = XLEN'($signed({w.raw[31], w.raw[7], w.raw[30:25], w.raw[11:8], 1'b0}));
      FMT_U:   imm_o = XLEN'($signed({w.raw[31:12], 12'b0}));
      FMT_J:   imm_o = XLEN'($signed({w.raw[31], w.raw[19:12], w.raw[20], w.raw[30:21], 1'b0}));
      FMT_Z:   imm_o = XLEN'(w.raw[19:15]);
      default: imm_o = '0;
    endcase
  end
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate-generation stage with valid/ready handshake, optional skid slot and flush.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  input  logic [2:0]      format_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);
  localparam int EW = 32 + XLEN + 1;
  logic [XLEN-1:0] imm_in;
  logic ill_in, acc, adv;
  logic [EW-1:0] in_e, out_q, out_d, skid_q, skid_d;
  logic out_v_q, out_v_d, skid_v_q, skid_v_d;
  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr_i  (instr_i),
    .format_i (formats_t'(format_i)),
    .imm_o    (imm_in),
    .illegal_o(ill_in)
  );
  assign in_e = {instr_i, imm_in, ill_in};
  assign ready_o = SKID_EN ? !skid_v_q : (!out_v_q || ready_i);
  assign acc = valid_i && ready_o && !flush_i;
  // output slot is free at this edge: either empty or being consumed
  assign adv = !out_v_q || ready_i;
  always_comb begin
    out_d    = (adv && skid_v_q) ? skid_q : (adv && acc) ? in_e : out_q;
    out_v_d  = !flush_i && (adv ? (skid_v_q || acc) : 1'b1);
    skid_d   = (acc && !adv) ? in_e : skid_q;
    skid_v_d = SKID_EN && !flush_i && !adv && (skid_v_q || acc);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end
  assign valid_o = out_v_q;
  assign {instr_o, imm_o, illegal_o} = out_q;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: scoreboard bench for an RV32 skid instance and an RV64 single-register instance.
module tb_imm_gen_stage;
  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic        ill;
  } ent_t;
  logic clk = 0, rst_n = 1, flush = 0, valid_i = 0, ready_i = 0;
  logic [31:0] instr = 0;
  logic [2:0] fmt = 0;
  logic v0, r0, l0, v1, r1, l1;
  logic [31:0] i0, i1, m0;
  logic [63:0] m1;
  logic vo[2], ro[2], il[2];
  logic [31:0] io[2];
  logic [63:0] imo[2];
  ent_t sb[2][$];
  int total = 0, bad = 0, n_acc0 = 0;
  bit have_exp = 0;
  logic [63:0] e0, e1;
  logic x0, x1;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_i), .ready_o(r0),
    .instr_i(instr), .format_i(fmt), .valid_o(v0), .ready_i(ready_i),
    .instr_o(i0), .imm_o(m0), .illegal_o(l0)
  );
  imm_gen_stage #(.XLEN(64), .SKID_EN(1'b0)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_i), .ready_o(r1),
    .instr_i(instr), .format_i(fmt), .valid_o(v1), .ready_i(ready_i),
    .instr_o(i1), .imm_o(m1), .illegal_o(l1)
  );

  always_comb begin
    vo[0] = v0; ro[0] = r0; io[0] = i0; imo[0] = {32'b0, m0}; il[0] = l0;
    vo[1] = v1; ro[1] = r1; io[1] = i1; imo[1] = m1; il[1] = l1;
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sx(longint v, int bits);
    return v >= (64'sd1 <<< (bits - 1)) ? v - (64'sd1 <<< bits) : v;
  endfunction

  // reference immediate from the format rules, plain arithmetic on the field values
  function automatic ent_t model(logic [31:0] w, int f, int xlen);
    ent_t e;
    longint v = 0;
    e.ill = 0;
    case (f)
      1: if (w[6:0] == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5)) begin
           v = xlen == 64 ? longint'(w[25:20]) : longint'(w[24:20]);
           e.ill = xlen == 32 && w[25];
         end else v = sx(longint'(w[31:20]), 12);
      2: v = sx(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
      3: v = sx(longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                + longint'(w[11:8]) * 2, 13);
      4: v = sx(longint'(w[31:12]) * 4096, 32);
      5: v = sx(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                + longint'(w[30:21]) * 2, 21);
      6: v = longint'(w[19:15]);
      7: e.ill = 1;
      default: v = 0;
    endcase
    e.instr = w;
    e.imm = xlen == 32 ? (v & 64'hFFFF_FFFF) : v;
    return e;
  endfunction

  function automatic ent_t mk(int s);
    ent_t e;
    e = model(instr, int'(fmt), s == 0 ? 32 : 64);
    if (have_exp) begin
      e.imm = s == 0 ? e0 : e1;
      e.ill = s == 0 ? x0 : x1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    int n;
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        n = sb[s].size();
        chk($sformatf("ready_o[%0d]", s), ro[s], s == 0 ? (n < 2) : (n == 0 || ready_i));
        chk($sformatf("valid_o[%0d]", s), vo[s], n > 0);
        if (vo[s] && n > 0) begin
          chk($sformatf("instr_o[%0d]", s), io[s], sb[s][0].instr);
          chk($sformatf("imm_o[%0d]", s), imo[s], sb[s][0].imm);
          chk($sformatf("illegal_o[%0d]", s), il[s], sb[s][0].ill);
        end
        if (flush) sb[s].delete();
        else if (vo[s] && ready_i && n > 0) void'(sb[s].pop_front());
      end
    end
  end

  task automatic cycle();
    @(negedge clk); #1;
    if (rst_n && !flush && valid_i) begin
      if (ro[0]) begin sb[0].push_back(mk(0)); n_acc0++; end
      if (ro[1]) sb[1].push_back(mk(1));
    end
    @(posedge clk); #1;
  endtask

  task automatic offer(logic [31:0] w, logic [2:0] f, bit he, logic [63:0] a0, logic b0,
                       logic [63:0] a1, logic b1);
    int start = n_acc0;
    instr = w; fmt = f; have_exp = he; e0 = a0; x0 = b0; e1 = a1; x1 = b1; valid_i = 1;
    for (int k = 0; k < 20 && n_acc0 == start; k++) cycle();
    chk("offer_accepted", n_acc0 != start, 1);
    valid_i = 0; have_exp = 0;
  endtask

  task automatic rnd_offer();
    logic [31:0] w = $urandom;
    if ($urandom % 2 == 0) w[6:0] = 7'h13;
    offer(w, 3'($urandom % 8), 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [31:0] w;
    #1 rst_n = 0;
    #2;
    chk("reset_valid", v0, 0);
    chk("reset_instr", i0, 0);
    chk("reset_imm", m0, 0);
    chk("reset_illegal", l0, 0);
    chk("reset_valid64", v1, 0);
    #10 rst_n = 1;
    #1 chk("ready_after_reset", r0, 1);
    @(posedge clk); #1;
    ready_i = 1;
    offer(32'hFFF00093, 3'd1, 1, 64'hFFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    offer(32'h40315093, 3'd1, 1, 64'd3, 0, 64'd3, 0);
    offer(32'h42015093, 3'd1, 1, 64'd0, 1, 64'd32, 0);
    offer(32'hFE000EE3, 3'd3, 1, 64'hFFFF_FFFC, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    offer(32'hFF9FF06F, 3'd5, 1, 64'hFFFF_FFF8, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    offer(32'h800000B7, 3'd4, 1, 64'h8000_0000, 0, 64'hFFFF_FFFF_8000_0000, 0);
    offer(32'h12345677, 3'd7, 1, 64'd0, 1, 64'd0, 1);
    repeat (3) cycle();
    // stalled output: A to output, B to skid, C held upstream
    ready_i = 0;
    base = n_acc0;
    rnd_offer();
    rnd_offer();
    instr = 32'hC0C0C0C3; fmt = 3'd2; valid_i = 1;
    repeat (2) cycle();
    chk("skid_full_ready", r0, 0);
    chk("c_held", n_acc0 - base, 2);
    ready_i = 1;
    for (int k = 0; k < 10 && n_acc0 - base == 2; k++) cycle();
    chk("c_accepted", n_acc0 - base, 3);
    valid_i = 0;
    repeat (4) cycle();
    // flush with skid full and an entry offered the same cycle
    ready_i = 0;
    rnd_offer();
    rnd_offer();
    flush = 1; valid_i = 1; instr = 32'hDEADBEEF; fmt = 3'd1;
    cycle();
    flush = 0; valid_i = 0;
    chk("flush_valid", v0, 0);
    chk("flush_ready", r0, 1);
    chk("flush_valid64", v1, 0);
    ready_i = 1;
    repeat (3) cycle();
    // asynchronous reset in the middle of a stall
    ready_i = 0;
    rnd_offer();
    rnd_offer();
    #3 rst_n = 0;
    #1;
    chk("async_reset_valid", v0, 0);
    chk("async_reset_valid64", v1, 0);
    sb[0].delete(); sb[1].delete();
    #3 rst_n = 1;
    @(posedge clk); #1;
    ready_i = 1;
    rnd_offer();
    chk("post_reset_latency", v0, 1);
    repeat (2) cycle();
    for (int c = 0; c < 1500; c++) begin
      w = $urandom;
      if ($urandom % 2 == 0) w[6:0] = 7'h13;
      instr = w; fmt = 3'($urandom % 8);
      valid_i = $urandom % 4 != 0;
      ready_i = $urandom % 3 != 0;
      flush = $urandom % 25 == 0;
      cycle();
    end
    valid_i = 0; flush = 0; ready_i = 1;
    repeat (5) cycle();
    chk("drained0", sb[0].size(), 0);
    chk("drained1", sb[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
